// File: rtl/mem_access_ctrl_if.sv
// Bundle of request-side (control unit) and memory-side (memory_unit) signals for mem_access_ctrl.
// slave = the sequencer's view; master = the control unit plus memory model view.
interface mem_access_ctrl_if;
  logic        Start;
  logic        ReadWrite;
  logic [1:0]  Size;
  logic        SignedLoad;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemEnable;
  logic        MemReadWrite;
  logic [31:0] MemAddress;
  logic [31:0] MemDataIn;
  logic [1:0]  MemWordSelector;
  logic [31:0] MemDataOut;
  logic        MFC;
  logic        Busy;
  logic        Done;
  logic        Fault;
  logic [1:0]  FaultCode;
  logic [31:0] ReadData;

  modport slave (
    input  Start, ReadWrite, Size, SignedLoad, Address, WriteData, MemDataOut, MFC,
    output MemEnable, MemReadWrite, MemAddress, MemDataIn, MemWordSelector,
           Busy, Done, Fault, FaultCode, ReadData
  );

  modport master (
    output Start, ReadWrite, Size, SignedLoad, Address, WriteData, MemDataOut, MFC,
    input  MemEnable, MemReadWrite, MemAddress, MemDataIn, MemWordSelector,
           Busy, Done, Fault, FaultCode, ReadData
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of memory_unit: MFC handshake, alignment and timeout faults, load extension.
// Define MEM_CTRL_MFC_SYNC_EN to pass MFC through a 2-flop synchronizer before use.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic Clk,
  input  logic Reset,
  mem_access_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_MFC, DONE} state_t;

  state_t      state_q, state_d;
  logic        rw_q, rw_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mfc;
  logic        misaligned;
  logic [31:0] load_ext;

`ifdef MEM_CTRL_MFC_SYNC_EN
  logic [1:0] mfc_sync_q;
  always_ff @(posedge Clk) begin
    if (Reset) mfc_sync_q <= 2'b00;
    else       mfc_sync_q <= {mfc_sync_q[0], bus.MFC};
  end
  assign mfc = mfc_sync_q[1];
`else
  assign mfc = bus.MFC;
`endif

  assign misaligned = ((bus.Size == 2'b01) && bus.Address[0]) ||
                      (bus.Size[1] && (bus.Address[1:0] != 2'b00));

  always_comb begin
    case (size_q)
      2'b00:   load_ext = {{24{sgn_q & bus.MemDataOut[7]}}, bus.MemDataOut[7:0]};
      2'b01:   load_ext = {{16{sgn_q & bus.MemDataOut[15]}}, bus.MemDataOut[15:0]};
      default: load_ext = bus.MemDataOut;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      code_q  <= 2'b00;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    code_d  = code_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          rw_d    = bus.ReadWrite;
          size_d  = bus.Size;
          sgn_d   = bus.SignedLoad;
          addr_d  = bus.Address;
          wdata_d = bus.WriteData;
          if (misaligned) begin
            state_d = DONE;
            fault_d = 1'b1;
            code_d  = 2'b01;
          end else begin
            state_d = WAIT_MFC;
            cnt_d   = '0;
            fault_d = 1'b0;
            code_d  = 2'b00;
          end
        end
      end
      WAIT_MFC: begin
        // MFC is checked first so that it wins over a coincident timeout
        if (mfc) begin
          if (rw_q) rdata_d = load_ext;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          fault_d = 1'b1;
          code_d  = 2'b10;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.MemEnable       = (state_q == WAIT_MFC);
  assign bus.MemReadWrite    = rw_q;
  assign bus.MemAddress      = addr_q;
  assign bus.MemDataIn       = wdata_q;
  assign bus.MemWordSelector = size_q[1] ? 2'b10 : size_q;
  assign bus.Busy            = (state_q != IDLE);
  assign bus.Done            = (state_q == DONE);
  assign bus.Fault           = fault_q;
  assign bus.FaultCode       = code_q;
  assign bus.ReadData        = rdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a short timeout; inputs change and outputs are sampled on negedge.
module tb_mem_access_ctrl;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Present a request for one edge; returns at the negedge after the Start edge.
  task automatic issue(input logic rw, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.Start = 1'b1; bus.ReadWrite = rw; bus.Size = size;
    bus.SignedLoad = sgn; bus.Address = addr; bus.WriteData = wdata;
    @(negedge Clk);
    bus.Start = 1'b0;
  endtask

  task automatic load_once(input string tag, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] dout,
                           input logic [31:0] exp);
    bus.MemDataOut = dout;
    issue(1'b1, size, sgn, addr, 32'h0);
    bus.MFC = 1'b1;
    @(negedge Clk);
    bus.MFC = 1'b0;
    check_eq({tag, "_done"}, {31'h0, bus.Done}, 32'h1);
    check_eq({tag, "_rdata"}, bus.ReadData, exp);
    @(negedge Clk);
  endtask

  initial begin
    int n;
    bus.Start = 1'b0; bus.ReadWrite = 1'b0; bus.Size = 2'b00; bus.SignedLoad = 1'b0;
    bus.Address = 32'h0; bus.WriteData = 32'h0; bus.MemDataOut = 32'h0; bus.MFC = 1'b0;
    repeat (2) @(negedge Clk);
    check_eq("rst_busy", {31'h0, bus.Busy}, 32'h0);
    check_eq("rst_done", {31'h0, bus.Done}, 32'h0);
    check_eq("rst_en", {31'h0, bus.MemEnable}, 32'h0);
    check_eq("rst_fault", {29'h0, bus.Fault, bus.FaultCode}, 32'h0);
    check_eq("rst_rdata", bus.ReadData, 32'h0);
    Reset = 1'b0;
    @(negedge Clk);

    // Word load, memory bytes 12,34,56,78 at 0x10, MFC after 3 cycles
    bus.MemDataOut = 32'h12345678;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
    check_eq("wl_en", {31'h0, bus.MemEnable}, 32'h1);
    check_eq("wl_addr", bus.MemAddress, 32'h10);
    check_eq("wl_rw", {31'h0, bus.MemReadWrite}, 32'h1);
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      check_eq("wl_sel", {30'h0, bus.MemWordSelector}, 32'h2);
      check_eq("wl_en_hold", {31'h0, bus.MemEnable}, 32'h1);
    end
    bus.MFC = 1'b1;
    @(negedge Clk);
    bus.MFC = 1'b0;
    check_eq("wl_done", {31'h0, bus.Done}, 32'h1);
    check_eq("wl_rdata", bus.ReadData, 32'h12345678);
    check_eq("wl_fault", {31'h0, bus.Fault}, 32'h0);
    check_eq("wl_en_done", {31'h0, bus.MemEnable}, 32'h0);
    @(negedge Clk);
    check_eq("wl_done_pulse", {31'h0, bus.Done}, 32'h0);
    check_eq("wl_idle", {31'h0, bus.Busy}, 32'h0);

    load_once("sb_s", 2'b00, 1'b1, 32'h11, 32'h00000085, 32'hFFFFFF85);
    load_once("sb_u", 2'b00, 1'b0, 32'h11, 32'h00000085, 32'h00000085);
    load_once("sh_s", 2'b01, 1'b1, 32'h12, 32'h12348001, 32'hFFFF8001);

    // Misaligned word
    issue(1'b1, 2'b10, 1'b0, 32'h22, 32'h0);
    check_eq("mis_en", {31'h0, bus.MemEnable}, 32'h0);
    check_eq("mis_done", {31'h0, bus.Done}, 32'h1);
    check_eq("mis_fault", {29'h0, bus.Fault, bus.FaultCode}, 32'h5);
    check_eq("mis_rdata", bus.ReadData, 32'hFFFF8001);
    @(negedge Clk);
    check_eq("mis_idle", {30'h0, bus.Busy, bus.Done}, 32'h0);

    // Timeout: Done after the 9th edge counting the Start edge
    issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h0);
    n = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.Done) begin n = i; break; end
      @(negedge Clk);
    end
    check_eq("to_latency", n, 8);
    check_eq("to_fault", {29'h0, bus.Fault, bus.FaultCode}, 32'h6);
    check_eq("to_en", {31'h0, bus.MemEnable}, 32'h0);
    check_eq("to_rdata", bus.ReadData, 32'hFFFF8001);
    @(negedge Clk);

    // Halfword store with an interfering Start while busy
    issue(1'b0, 2'b01, 1'b0, 32'h40, 32'h0000ABCD);
    check_eq("st_fault_clr", {29'h0, bus.Fault, bus.FaultCode}, 32'h0);
    check_eq("st_rw", {31'h0, bus.MemReadWrite}, 32'h0);
    check_eq("st_din", bus.MemDataIn, 32'h0000ABCD);
    check_eq("st_sel", {30'h0, bus.MemWordSelector}, 32'h1);
    issue(1'b1, 2'b10, 1'b0, 32'h80, 32'h11111111);
    check_eq("st_ign_addr", bus.MemAddress, 32'h40);
    check_eq("st_ign_din", bus.MemDataIn, 32'h0000ABCD);
    check_eq("st_ign_sel", {30'h0, bus.MemWordSelector}, 32'h1);
    bus.MFC = 1'b1;
    @(negedge Clk);
    bus.MFC = 1'b0;
    check_eq("st_done", {31'h0, bus.Done}, 32'h1);
    check_eq("st_rdata", bus.ReadData, 32'hFFFF8001);
    @(negedge Clk);
    @(negedge Clk);
    check_eq("st_no_queue", {30'h0, bus.Busy, bus.Done}, 32'h0);

    // MFC on the same edge as the timeout: success wins; Size=11 maps to word
    bus.MemDataOut = 32'hCAFEF00D;
    issue(1'b1, 2'b11, 1'b0, 32'h30, 32'h0);
    check_eq("co_sel", {30'h0, bus.MemWordSelector}, 32'h2);
    repeat (7) @(negedge Clk);
    bus.MFC = 1'b1;
    @(negedge Clk);
    bus.MFC = 1'b0;
    check_eq("co_done", {31'h0, bus.Done}, 32'h1);
    check_eq("co_fault", {29'h0, bus.Fault, bus.FaultCode}, 32'h0);
    check_eq("co_rdata", bus.ReadData, 32'hCAFEF00D);
    @(negedge Clk);

    // Reset mid-WAIT_MFC
    issue(0, 2'b10, 1'b0, 32'h50, 32'h5A5A5A5A);
    check_eq("mr_en_pre", {31'h0, bus.MemEnable}, 32'h1);
    Reset = 1'b1;
    @(negedge Clk);
    check_eq("mr_ctl", {28'h0, bus.MemEnable, bus.Busy, bus.Done, bus.MemReadWrite}, 32'h0);
    check_eq("mr_addr", bus.MemAddress, 32'h0);
    check_eq("mr_din", bus.MemDataIn, 32'h0);
    check_eq("mr_sel_flt", {27'h0, bus.MemWordSelector, bus.Fault, bus.FaultCode}, 32'h0);
    check_eq("mr_rdata", bus.ReadData, 32'h0);
    Reset = 1'b0;
    @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
